// File: rtl/audio_pkg.sv
// Shared audio types and frame layout for the I2S transmit path.
// Optional I2S_TX_UNDERRUN_CNT_EN adds an underrun counter to the top.
package audio_pkg;

  localparam int DATA_WIDTH_DEFAULT = 24;
  localparam int SAMPLE_BITS = 24;
  localparam int SLOT_BITS = 32;
  localparam int FRAME_BITS = 64;
  localparam int PAD_BITS = SLOT_BITS - SAMPLE_BITS;

  typedef enum logic [1:0] {
    WAIT_LEFT  = 2'd0,
    WAIT_RIGHT = 2'd1,
    FULL       = 2'd2
  } tx_state_t;

  // One-bit I2S delay: MSB of each word lands one slot after lrck flips.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [SAMPLE_BITS-1:0] l,
    input logic [SAMPLE_BITS-1:0] r
  );
    return {1'b0, l, {PAD_BITS{1'b0}},
            r, {(PAD_BITS-1){1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// Free-running frame counter producing mclk/sclk/lrck and strobes.
// Clocks are bits of the counter register, so they are glitch-free.
module i2s_clock_gen #(
  parameter int CNT_WIDTH = 9
) (
  input  logic clk,
  input  logic resetn,
  output logic mclk,
  output logic sclk,
  output logic lrck,
  output logic frame_end,
  output logic bit_tick
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign mclk      = cnt[0];
  assign sclk      = cnt[2];
  assign lrck      = cnt[CNT_WIDTH-1];
  assign frame_end = &cnt;
  assign bit_tick  = &cnt[2:0];

endmodule

// File: rtl/axis_i2s_transmitter.sv
// AXI-Stream stereo pairs in, 64-slot I2S frames out.
// Define I2S_TX_UNDERRUN_CNT_EN to add the underrun_count output.
module axis_i2s_transmitter
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  mclk,
  output logic                  sclk,
  output logic                  lrck,
  output logic                  sdout,
  output logic                  underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  logic frame_end;
  logic bit_tick;

  i2s_clock_gen #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_clk (
    .clk      (clk),
    .resetn   (resetn),
    .mclk     (mclk),
    .sclk     (sclk),
    .lrck     (lrck),
    .frame_end(frame_end),
    .bit_tick (bit_tick)
  );

  logic [SAMPLE_BITS-1:0] sample;

  generate
    if (DATA_WIDTH >= SAMPLE_BITS) begin : g_trunc
      assign sample = s_data[DATA_WIDTH-1 -: SAMPLE_BITS];
    end else begin : g_pad
      assign sample = {s_data,
                       {(SAMPLE_BITS-DATA_WIDTH){1'b0}}};
    end
  endgenerate

  tx_state_t              state;
  logic [SAMPLE_BITS-1:0] left_q;
  logic [SAMPLE_BITS-1:0] right_q;
  logic [FRAME_BITS-1:0]  shreg;
  logic                   accept;

  assign accept = s_valid && s_ready;

  // s_ready tracks the next state so it never depends on inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= WAIT_LEFT;
      s_ready <= 1'b1;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      case (state)
        WAIT_LEFT: begin
          if (accept && !s_last) begin
            left_q <= sample;
            state  <= WAIT_RIGHT;
          end
        end
        WAIT_RIGHT: begin
          if (accept) begin
            if (s_last) begin
              right_q <= sample;
              state   <= FULL;
              s_ready <= 1'b0;
            end else begin
              left_q <= sample;
            end
          end
        end
        FULL: begin
          if (frame_end) begin
            state   <= WAIT_LEFT;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= WAIT_LEFT;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

  // Frame load wins over the last shift of the old frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_end && (state != FULL);
      if (frame_end) begin
        shreg <= (state == FULL) ?
                 pack_frame(left_q, right_q) : '0;
      end else if (bit_tick) begin
        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  assign sdout = shreg[FRAME_BITS-1];

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/axis_i2s_transmitter.md
AXIS_I2S_TRANSMITTER -- requirements
Module: axis_i2s_transmitter

Interface
REQ-001 Parameter: DATA_WIDTH, default 24, width of the audio sample on s_data.
REQ-002 Parameter: CNT_WIDTH, default 9, width of the frame counter; one frame = 2^CNT_WIDTH clk cycles.
REQ-003 clk  input  1  system clock, 45.1584 MHz nominal; all logic on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 s_data  input  DATA_WIDTH  AXIS slave sample, signed two's complement.
REQ-006 s_valid  input  1  AXIS slave valid.
REQ-007 s_last  input  1  AXIS slave last; 0 = left word, 1 = right word (ends the stereo packet).
REQ-008 s_ready  output  1  AXIS slave ready.
REQ-009 mclk  output  1  I2S master clock = clk/2.
REQ-010 sclk  output  1  I2S bit clock = clk/8, 64 SCLK per frame.
REQ-011 lrck  output  1  I2S word select = clk/512; 0 = left, 1 = right.
REQ-012 sdout  output  1  I2S serial data, MSB first.
REQ-013 underrun  output  1  one-cycle pulse when a frame boundary finds no complete stereo pair.

Function
REQ-014 Free-running counter cnt[CNT_WIDTH-1:0] increments every clk and wraps 511->0; mclk=cnt[0], sclk=cnt[2], lrck=cnt[8], all registered.
REQ-015 Input state machine: WAIT_LEFT, WAIT_RIGHT, FULL; s_ready = 1 in WAIT_LEFT/WAIT_RIGHT, 0 in FULL; s_ready is driven from state registers only.
REQ-016 WAIT_LEFT: accepted word with s_last=0 -> store as left, go WAIT_RIGHT; accepted word with s_last=1 -> discarded, stay (resync).
REQ-017 WAIT_RIGHT: accepted word with s_last=1 -> store as right, go FULL; accepted word with s_last=0 -> overwrites left, stay (resync).
REQ-018 At cnt==511, state FULL: shift register (64 bits) loads {1'b0, left, 8'b0, right, 7'b0}; state -> WAIT_LEFT.
REQ-019 At cnt==511, state not FULL: shift register loads all zeros, underrun pulses next cycle, and a partial pair is preserved (state unchanged).
REQ-020 sdout = shift register MSB; shift left by one when cnt[2:0]==3'b111 and cnt!=511, so sdout changes coincident with sclk falling.
REQ-021 Result: one-bit I2S delay; left MSB in bit slot 1, right MSB in slot 33; slots 25-32 and 57-63 are 0.
REQ-022 Latency: a pair completed before cnt==511 starts on sdout at cnt==0 (lrck falling); a pair completed on or after cnt==511 waits one full frame.
REQ-023 At cnt==511 in FULL, s_ready is 0 that cycle; it rises the next cycle (no same-cycle accept and load).
REQ-024 Samples wider than 24 bits: only the 24 MSBs are transmitted; narrower samples are left-justified, zero-padded.

Reset
REQ-025 resetn low: cnt=0, state=WAIT_LEFT, buffers and shift register zero; mclk=sclk=lrck=sdout=0, underrun=0, s_ready=1.
REQ-026 Reset asserted mid-frame or mid-pair: the partial pair is discarded, and output restarts from a fresh frame after release.

Configuration
REQ-027 Macro I2S_TX_UNDERRUN_CNT_EN defined: adds output underrun_count [15:0], a saturating count of underrun pulses, reset to 0, holding at 16'hFFFF.
REQ-028 Macro absent: no underrun_count port and no counter logic; all other behaviour is identical.

Structure
REQ-029 Package audio_pkg holds: DATA_WIDTH default, SLOT_BITS=32, FRAME_BITS=64, the tx_state_t enum (WAIT_LEFT, WAIT_RIGHT, FULL).
REQ-030 One sub-module, i2s_clock_gen, owns cnt and drives mclk/sclk/lrck plus a frame_end strobe (cnt==511) and a bit_tick strobe (cnt[2:0]==7).

Verification
REQ-031 Reset release, L=24'h800001, R=24'h7FFFFE sent before cnt 511 -> next frame sdout slot1..24 = 800001, slot33..56 = 7FFFFE, other slots 0.
REQ-032 No input for 3 frames -> sdout all 0, three underrun pulses, each at cnt==0; with macro, underrun_count=3.
REQ-033 Stream s_last=1, then L=24'h123456 (last=0), then R=24'hABCDEF (last=1) -> first word dropped; frame carries 123456/ABCDEF.
REQ-034 Pair completes, then a third word is offered while FULL -> s_ready=0 until the cycle after cnt==511, then the word is accepted.
REQ-035 resetn pulsed low at cnt==200 with the left word held -> all outputs 0, left discarded, and the frame after release is an underrun.
REQ-036 Clock check over 1024 cycles -> mclk period 2, sclk period 8, lrck period 512; sdout transitions only on sclk falling edges.
